lmsm_sequencer: RTL and testbench
=================================

LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 SHALL have parameter: ADDR_W, 16, width of memory address path.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: proc_rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  in  1  one-cycle request to begin an LM/SM block transfer.
REQ-005 SHALL have port: is_store  in  1  1 = SM (register to memory), 0 = LM (memory to register); sampled with start.
REQ-006 SHALL have port: reg_list  in  8  register-select bitmap from IR[7:0], bit i selects Ri; sampled with start.
REQ-007 SHALL have port: base_addr  in  ADDR_W  first memory address, sampled with start.
REQ-008 SHALL have port: stall  in  1  memory not ready; freezes the transfer.
REQ-009 SHALL have port: busy  out  1  high in XFER and DONE states.
REQ-010 SHALL have port: reg_idx  out  3  register index of the current transfer.
REQ-011 SHALL have port: mem_addr  out  ADDR_W  memory address of the current transfer.
REQ-012 SHALL have port: rf_wen  out  1  register-file write enable (LM step).
REQ-013 SHALL have port: mem_wen  out  1  memory write enable (SM step).
REQ-014 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-015 SHALL have port: xfer_count  out  4  number of registers transferred in the current or last block (0-8).

Function
REQ-016 SHALL implement FSM states IDLE, XFER, DONE; the state register, pending bitmap (8b), address register (ADDR_W), mode bit and xfer_count are the only storage.
REQ-017 IDLE: on start=1, SHALL latch reg_list->pending, base_addr->address, is_store->mode, clear xfer_count; next state XFER if reg_list!=0, else DONE.
REQ-018 start SHALL be ignored in XFER and DONE; a new block is accepted only in IDLE.
REQ-019 XFER: reg_idx SHALL equal the index of the lowest set bit of pending (R0 first, R7 last); mem_addr SHALL equal the address register.
REQ-020 XFER with stall=0: rf_wen=~mode, mem_wen=mode for that cycle; at the clock edge the selected pending bit clears, address increments by 1, and xfer_count increments by 1.
REQ-021 XFER with stall=1: rf_wen=mem_wen=0; pending, address, xfer_count and state held; reg_idx/mem_addr unchanged.
REQ-022 XFER: when the step that clears the last pending bit completes, next state SHALL be DONE; otherwise remain in XFER.
REQ-023 DONE: done=1 for exactly one cycle, rf_wen=mem_wen=0; next state IDLE unconditionally; stall ignored.
REQ-024 Latency: start accepted at edge N with k bits set and no stalls -> k enable cycles N+1..N+k, done high in cycle N+k+1, busy low from N+k+2; each stall cycle adds one cycle.
REQ-025 Address arithmetic SHALL be modulo 2^ADDR_W (all-ones + 1 wraps to 0).
REQ-026 Addresses SHALL be consecutive per transferred register regardless of gaps in reg_list (list 0x81 -> R0@base, R7@base+1).
REQ-027 In IDLE and DONE, reg_idx=0 and mem_addr=address register; in IDLE rf_wen, mem_wen and done are 0.
REQ-028 xfer_count SHALL hold its final value through DONE and IDLE until the next accepted start.

Reset
REQ-029 proc_rst=1 at a clock edge SHALL force IDLE, pending=0, address=0, mode=0, xfer_count=0; takes priority over start and stall.
REQ-030 During and after reset: busy=0, done=0, rf_wen=0, mem_wen=0, reg_idx=0, mem_addr=0.
REQ-031 Reset mid-XFER SHALL abort the block with no further enables and no done pulse.

Verification
REQ-032 LM, reg_list=0x0B, base=0x0040, no stall -> rf_wen 3 cycles with (reg_idx,mem_addr)=(0,0x40),(1,0x41),(3,0x42); mem_wen=0; done next cycle; xfer_count=3.
REQ-033 SM, reg_list=0xFF, base=0xFFFE -> mem_wen 8 cycles, idx 0..7, addresses 0xFFFE,0xFFFF,0x0000..0x0005; done; xfer_count=8.
REQ-034 reg_list=0x00 with start -> no enables, done exactly one cycle after start, xfer_count=0.
REQ-035 SM reg_list=0x06, stall=1 for 2 cycles during first step -> R1@base held with mem_wen=0 while stalled, then R1@base, R2@base+1; done 2 cycles later than unstalled.
REQ-036 start re-pulsed during XFER with different list -> ignored, original sequence completes unchanged.
REQ-037 proc_rst during 3rd step of an 8-register LM -> next cycle all outputs at reset values, no done; new start afterwards runs normally.

Source files
------------

// File: rtl/lmsm_sequencer_if.sv
// Request/transfer bundle between the LM/SM block-transfer sequencer and its
// requester, register file and memory port.
interface lmsm_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              is_store;
    logic [7:0]        reg_list;
    logic [ADDR_W-1:0] base_addr;
    logic              stall;
    logic              busy;
    logic [2:0]        reg_idx;
    logic [ADDR_W-1:0] mem_addr;
    logic              rf_wen;
    logic              mem_wen;
    logic              done;
    logic [3:0]        xfer_count;

    modport master (
        output start, is_store, reg_list, base_addr, stall,
        input  busy, reg_idx, mem_addr, rf_wen, mem_wen, done, xfer_count
    );

    modport slave (
        input  start, is_store, reg_list, base_addr, stall,
        output busy, reg_idx, mem_addr, rf_wen, mem_wen, done, xfer_count
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple sequencer: walks a register bitmap lowest bit
// first, issuing one register-file or memory write per unstalled cycle.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet, xfer_count holds last result
// XFER  | one register per unstalled cycle, lowest pending bit first
// DONE  | one-cycle completion pulse, then back to IDLE
module lmsm_sequencer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              proc_rst,
    lmsm_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state;
    logic [7:0]        pending;
    logic [ADDR_W-1:0] addr;
    logic              mode;
    logic [3:0]        count;

    logic [2:0]        low_idx;
    logic [7:0]        low_bit;
    logic [7:0]        pending_next;
    logic              step;

    always_comb begin
        low_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) low_idx = 3'(i);
        end
    end

    assign low_bit      = 8'(1) << low_idx;
    assign pending_next = pending & ~low_bit;
    assign step         = (state == XFER) && !bus.stall && !proc_rst;

    always_ff @(posedge clk) begin
        if (proc_rst) begin
            state   <= IDLE;
            pending <= '0;
            addr    <= '0;
            mode    <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        pending <= bus.reg_list;
                        addr    <= bus.base_addr;
                        mode    <= bus.is_store;
                        count   <= '0;
                        state   <= (bus.reg_list != 8'h00) ? XFER : DONE;
                    end
                end
                XFER: begin
                    if (!bus.stall) begin
                        pending <= pending_next;
                        addr    <= addr + 1'b1;
                        count   <= count + 4'd1;
                        if (pending_next == 8'h00) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while reset is asserted so an aborted block
    // cannot leak a final enable in the reset cycle.
    assign bus.busy       = !proc_rst && (state != IDLE);
    assign bus.done       = !proc_rst && (state == DONE);
    assign bus.rf_wen     = step && !mode;
    assign bus.mem_wen    = step && mode;
    assign bus.reg_idx    = (!proc_rst && state == XFER) ? low_idx : 3'd0;
    assign bus.mem_addr   = proc_rst ? '0 : addr;
    assign bus.xfer_count = proc_rst ? 4'd0 : count;
endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for the LM/SM sequencer: fixed-cycle stimulus with
// hand-derived expected output values for every cycle.
module tb_lmsm_sequencer;
    logic clk;
    logic proc_rst;
    int   total;
    int   bad;

    lmsm_sequencer_if #(.ADDR_W(16)) bus ();

    lmsm_sequencer #(.ADDR_W(16)) dut (
        .clk      (clk),
        .proc_rst (proc_rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then drive this cycle's inputs.
    task automatic cyc(input logic rst, input logic st, input logic sm,
                       input logic [7:0] list, input logic [15:0] base, input logic stl);
        @(posedge clk);
        #2;
        proc_rst      = rst;
        bus.start     = st;
        bus.is_store  = sm;
        bus.reg_list  = list;
        bus.base_addr = base;
        bus.stall     = stl;
        #2;
    endtask

    task automatic expect_out(input string tag, input logic rf, input logic mw,
                              input logic [2:0] idx, input logic [15:0] addr,
                              input logic dn, input logic bz, input logic [3:0] cnt);
        check({tag, ".rf_wen"},     32'(bus.rf_wen),     32'(rf));
        check({tag, ".mem_wen"},    32'(bus.mem_wen),    32'(mw));
        check({tag, ".reg_idx"},    32'(bus.reg_idx),    32'(idx));
        check({tag, ".mem_addr"},   32'(bus.mem_addr),   32'(addr));
        check({tag, ".done"},       32'(bus.done),       32'(dn));
        check({tag, ".busy"},       32'(bus.busy),       32'(bz));
        check({tag, ".xfer_count"}, 32'(bus.xfer_count), 32'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        proc_rst      = 1'b1;
        bus.start     = 1'b0;
        bus.is_store  = 1'b0;
        bus.reg_list  = 8'h00;
        bus.base_addr = 16'h0000;
        bus.stall     = 1'b0;

        // Reset state
        cyc(1, 0, 0, 8'h00, 16'h0000, 0);
        cyc(1, 1, 1, 8'hFF, 16'h1111, 1);
        expect_out("rst_hold", 0, 0, 0, 16'h0000, 0, 0, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("rst_after", 0, 0, 0, 16'h0000, 0, 0, 0);

        // LM 0x0B @0x0040
        cyc(0, 1, 0, 8'h0B, 16'h0040, 0);
        expect_out("lm0b_idle", 0, 0, 0, 16'h0000, 0, 0, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("lm0b_s0", 1, 0, 0, 16'h0040, 0, 1, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("lm0b_s1", 1, 0, 1, 16'h0041, 0, 1, 1);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("lm0b_s2", 1, 0, 3, 16'h0042, 0, 1, 2);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("lm0b_done", 0, 0, 0, 16'h0043, 1, 1, 3);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("lm0b_idle2", 0, 0, 0, 16'h0043, 0, 0, 3);

        // SM 0xFF @0xFFFE, address wraps
        cyc(0, 1, 1, 8'hFF, 16'hFFFE, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 8'h00, 16'h0000, 0);
            expect_out($sformatf("smff_s%0d", i), 0, 1, 3'(i), 16'(16'hFFFE + i), 0, 1, 4'(i));
        end
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("smff_done", 0, 0, 0, 16'h0006, 1, 1, 8);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("smff_idle", 0, 0, 0, 16'h0006, 0, 0, 8);

        // Empty list goes straight to DONE
        cyc(0, 1, 0, 8'h00, 16'h1234, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("empty_done", 0, 0, 0, 16'h1234, 1, 1, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("empty_idle", 0, 0, 0, 16'h1234, 0, 0, 0);

        // SM 0x06 @0x0200 with two stall cycles on the first step; stall in DONE ignored
        cyc(0, 1, 1, 8'h06, 16'h0200, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 1);
        expect_out("stall_a", 0, 0, 1, 16'h0200, 0, 1, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 1);
        expect_out("stall_b", 0, 0, 1, 16'h0200, 0, 1, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("stall_s0", 0, 1, 1, 16'h0200, 0, 1, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("stall_s1", 0, 1, 2, 16'h0201, 0, 1, 1);
        cyc(0, 0, 0, 8'h00, 16'h0000, 1);
        expect_out("stall_done", 0, 0, 0, 16'h0202, 1, 1, 2);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("stall_idle", 0, 0, 0, 16'h0202, 0, 0, 2);

        // Gapped list 0x81: consecutive addresses; start during XFER/DONE ignored
        cyc(0, 1, 0, 8'h81, 16'h0010, 0);
        cyc(0, 1, 1, 8'hF0, 16'h0099, 0);
        expect_out("gap_s0", 1, 0, 0, 16'h0010, 0, 1, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("gap_s1", 1, 0, 7, 16'h0011, 0, 1, 1);
        cyc(0, 1, 1, 8'h01, 16'h0777, 0);
        expect_out("gap_done", 0, 0, 0, 16'h0012, 1, 1, 2);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("gap_idle", 0, 0, 0, 16'h0012, 0, 0, 2);

        // Reset during third step of an 8-register LM, then a fresh block
        cyc(0, 1, 0, 8'hFF, 16'h0300, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("abort_s0", 1, 0, 0, 16'h0300, 0, 1, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("abort_s1", 1, 0, 1, 16'h0301, 0, 1, 1);
        cyc(1, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("abort_rst", 0, 0, 0, 16'h0000, 0, 0, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("abort_after", 0, 0, 0, 16'h0000, 0, 0, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("abort_quiet", 0, 0, 0, 16'h0000, 0, 0, 0);
        cyc(0, 1, 0, 8'h01, 16'h0055, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("rerun_s0", 1, 0, 0, 16'h0055, 0, 1, 0);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("rerun_done", 0, 0, 0, 16'h0056, 1, 1, 1);
        cyc(0, 0, 0, 8'h00, 16'h0000, 0);
        expect_out("rerun_idle", 0, 0, 0, 16'h0056, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
